mem_bus_arbiter: RTL

//  Shares the data-memory/IO bus between two requesters: M0 = CPU control unit, M1 = DMA engine.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 15 +
 rtl/mem_bus_arbiter_addr_decode.sv | 18 +
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory/IO bus arbiter: state encodings,
// master indices, default address map and the round-robin pick helper.
package mem_bus_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_DONE   = 2'd2;

  // Master indices (also the encoding of owner)
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Default address map, matching the bus interface unit
  localparam int unsigned ARB_IO_STOP_ADDR   = 32'h0000_003F;
  localparam int unsigned ARB_MEM_START_ADDR = 32'h0000_0040;
  localparam int unsigned ARB_MEM_STOP_ADDR  = 32'h0000_00BF;

  // Round-robin pick: a lone requester wins, a tie goes to the non-owner.
  function automatic logic arb_pick(input logic req0, input logic req1,
                                    input logic owner);
    if (req0 && req1) return !owner;
    else if (req1)    return ARB_M1;
    else              return ARB_M0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle: one instance per bus master.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;

  modport master (output req, lock, addr, we, wdata, input ack);
  modport slave  (input req, lock, addr, we, wdata, output ack);
endinterface

// File: rtl/mem_bus_arbiter_addr_decode.sv
// Combinational address decode into IO / data-memory regions.
module arb_addr_decode #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned IO_STOP_ADDR   = 32'h3F,
  parameter int unsigned MEM_START_ADDR = 32'h40,
  parameter int unsigned MEM_STOP_ADDR  = 32'hBF
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_is_io,
  output logic                  o_is_mem
);
  localparam logic [ADDR_WIDTH-1:0] LP_IO_STOP   = ADDR_WIDTH'(IO_STOP_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_MEM_START = ADDR_WIDTH'(MEM_START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_MEM_STOP  = ADDR_WIDTH'(MEM_STOP_ADDR);

  assign o_is_io  = (i_addr <= LP_IO_STOP);
  assign o_is_mem = (i_addr >= LP_MEM_START) && (i_addr <= LP_MEM_STOP);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory/IO bus (M0 = CPU, M1 = DMA).
// Per-access round-robin, locked back-to-back accesses, registered read data.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned IO_STOP_ADDR   = ARB_IO_STOP_ADDR,
  parameter int unsigned MEM_START_ADDR = ARB_MEM_START_ADDR,
  parameter int unsigned MEM_STOP_ADDR  = ARB_MEM_STOP_ADDR,
  parameter int unsigned LOCK_MAX       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_bus_arbiter_if.slave      m0,
  mem_bus_arbiter_if.slave      m1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  owner,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  io_cs,
  output logic                  io_we,
  output logic                  io_oe
);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] LP_LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  logic [1:0]            r_state;
  logic                  r_owner;
  logic [CNT_W-1:0]      r_lock_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_req;
  logic                  w_lock;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_is_io;
  logic                  w_is_mem;
  logic                  w_access;
  logic                  w_done;

  // Owner-side request mux
  assign w_req   = r_owner ? m1.req   : m0.req;
  assign w_lock  = r_owner ? m1.lock  : m0.lock;
  assign w_we    = r_owner ? m1.we    : m0.we;
  assign w_addr  = r_owner ? m1.addr  : m0.addr;
  assign w_wdata = r_owner ? m1.wdata : m0.wdata;

  arb_addr_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .IO_STOP_ADDR   (IO_STOP_ADDR),
    .MEM_START_ADDR (MEM_START_ADDR),
    .MEM_STOP_ADDR  (MEM_STOP_ADDR)
  ) u_decode (
    .i_addr   (w_addr),
    .o_is_io  (w_is_io),
    .o_is_mem (w_is_mem)
  );

  assign w_access = (r_state == ARB_ACCESS);
  assign w_done   = (r_state == ARB_DONE);

  // Strobes and bus drive are decoded from the registered state, so an
  // asynchronous reset drops them immediately.
  assign mem_cs    = w_access && w_is_mem;
  assign mem_we    = mem_cs && w_we;
  assign mem_oe    = mem_cs && !w_we;
  assign io_cs     = w_access && w_is_io;
  assign io_we     = io_cs && w_we;
  assign io_oe     = io_cs && !w_we;
  assign bus_addr  = w_access ? w_addr  : '0;
  assign bus_wdata = w_access ? w_wdata : '0;

  assign m0.ack = w_done && (r_owner == ARB_M0);
  assign m1.ack = w_done && (r_owner == ARB_M1);
  assign rdata  = r_rdata;
  assign owner  = r_owner;
  assign busy   = (r_state != ARB_IDLE);

  // Arbitration FSM, lock counter and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= ARB_M1;
      r_lock_cnt <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (m0.req || m1.req) begin
            r_owner <= arb_pick(m0.req, m1.req, r_owner);
            r_state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (!w_we) r_rdata <= (w_is_io || w_is_mem) ? bus_rdata : '1;
          r_state <= ARB_DONE;
        end
        ARB_DONE: begin
          if (w_req && w_lock && (r_lock_cnt < LP_LOCK_LAST)) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            r_state    <= ARB_ACCESS;
          end else begin
            r_lock_cnt <= '0;
            r_state    <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
